// File: rtl/uart_hex_cmd_rx.sv
// 8N1 UART receiver plus parser for "0xAAAA 0xDD" LF CR command lines.
// Decoded address/value pairs are presented on a valid/ready interface.
module uart_hex_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_err,
  output logic        parse_err,
  output logic        overrun
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfBit = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  localparam logic [7:0] Ch0  = 8'h30;
  localparam logic [7:0] ChX  = 8'h78;
  localparam logic [7:0] ChXu = 8'h58;
  localparam logic [7:0] ChSp = 8'h20;
  localparam logic [7:0] ChLf = 8'h0A;
  localparam logic [7:0] ChCr = 8'h0D;

  typedef enum logic [2:0] {RIdle, RStart, RData, RStop, RWait} rx_state_e;
  typedef enum logic [3:0] {P0, PX, PA, PSp, P0b, PXb, PD, PLf, PCr, PSync} parse_state_e;

  rx_state_e    rx_state;
  parse_state_e p_state;

  logic            rx_s1, rx_s2;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [15:0]     addr_sh;
  logic [7:0]      data_sh;
  logic [1:0]      nib_cnt;

  logic       hex_ok;
  logic [3:0] hex_nib;
  logic [7:0] hex_tmp;
  logic       is_x;
  logic       byte_ok;

  // Two-flop synchroniser; preset high so reset looks like an idle line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state      <= RIdle;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      frame_err     <= 1'b0;
      case (rx_state)
        RIdle: begin
          if (!rx_s2) begin
            rx_state <= RStart;
            baud_cnt <= '0;
          end
        end
        RStart: begin
          if (baud_cnt == HalfBit) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s2 ? RIdle : RData;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RData: begin
          if (baud_cnt == LastCnt) begin
            baud_cnt <= '0;
            shift    <= {rx_s2, shift[7:1]};
            if (bit_idx == 3'd7) rx_state <= RStop;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RStop: begin
          if (baud_cnt == LastCnt) begin
            baud_cnt <= '0;
            if (rx_s2) begin
              rx_byte       <= shift;
              rx_byte_valid <= 1'b1;
              rx_state      <= RIdle;
            end else begin
              frame_err <= 1'b1;
              rx_state  <= RWait;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RWait: begin
          if (rx_s2) rx_state <= RIdle;
        end
        default: rx_state <= RIdle;
      endcase
    end
  end

  always_comb begin
    hex_ok  = 1'b0;
    hex_tmp = 8'h00;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      hex_ok  = 1'b1;
      hex_tmp = rx_byte - 8'h30;
    end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
      hex_ok  = 1'b1;
      hex_tmp = rx_byte - 8'h37;
    end else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
      hex_ok  = 1'b1;
      hex_tmp = rx_byte - 8'h57;
    end
    hex_nib = hex_tmp[3:0];
    is_x    = (rx_byte == ChX) || (rx_byte == ChXu);
  end

  always_comb begin
    byte_ok = 1'b0;
    case (p_state)
      P0:       byte_ok = (rx_byte == Ch0) || (rx_byte == ChCr);
      PX, PXb:  byte_ok = is_x;
      PA, PD:   byte_ok = hex_ok;
      PSp:      byte_ok = (rx_byte == ChSp);
      P0b:      byte_ok = (rx_byte == Ch0);
      PLf:      byte_ok = (rx_byte == ChLf);
      PCr:      byte_ok = (rx_byte == ChCr);
      PSync:    byte_ok = 1'b1;
      default:  byte_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state   <= P0;
      addr_sh   <= '0;
      data_sh   <= '0;
      nib_cnt   <= '0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_valid <= 1'b0;
      parse_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      parse_err <= 1'b0;
      overrun   <= 1'b0;
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;
      if (rx_byte_valid) begin
        if (!byte_ok) begin
          parse_err <= 1'b1;
          p_state   <= PSync;
          addr_sh   <= '0;
          data_sh   <= '0;
          nib_cnt   <= '0;
        end else begin
          case (p_state)
            P0:  if (rx_byte == Ch0) p_state <= PX;
            PX: begin
              p_state <= PA;
              nib_cnt <= '0;
            end
            PA: begin
              addr_sh <= {addr_sh[11:0], hex_nib};
              if (nib_cnt == 2'd3) begin
                p_state <= PSp;
                nib_cnt <= '0;
              end else begin
                nib_cnt <= nib_cnt + 1'b1;
              end
            end
            PSp: p_state <= P0b;
            P0b: p_state <= PXb;
            PXb: begin
              p_state <= PD;
              nib_cnt <= '0;
            end
            PD: begin
              data_sh <= {data_sh[3:0], hex_nib};
              if (nib_cnt == 2'd1) begin
                p_state <= PLf;
                nib_cnt <= '0;
              end else begin
                nib_cnt <= nib_cnt + 1'b1;
              end
            end
            PLf: p_state <= PCr;
            PCr: begin
              p_state <= P0;
              // A same-cycle acceptance frees the slot for the new command.
              if (!cmd_valid || cmd_ready) begin
                cmd_addr  <= addr_sh;
                cmd_data  <= data_sh;
                cmd_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
            PSync: if (rx_byte == ChCr) p_state <= P0;
            default: p_state <= P0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_cmd_rx.sv
// Scoreboard bench for uart_hex_cmd_rx: stimulus queues expected bytes/commands,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_uart_hex_cmd_rx;

  localparam int unsigned Cpb = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        cmd_ready = 1'b1;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        frame_err;
  logic        parse_err;
  logic        overrun;

  uart_hex_cmd_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_err     (frame_err),
    .parse_err     (parse_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_rx_q[$];
  logic [23:0] exp_cmd_q[$];

  int n_rxv = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_cmd = 0;
  int s_rxv, s_ferr, s_perr, s_ovr, s_cmd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: compares presented bytes/commands against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_byte_valid) begin
        n_rxv++;
        if (exp_rx_q.size() == 0) check("rx_byte_unexpected", {24'h0, rx_byte}, 32'h100);
        else check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_rx_q.pop_front()});
      end
      if (cmd_valid && cmd_ready) begin
        n_cmd++;
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", {8'h0, cmd_addr, cmd_data}, 32'h1000000);
        else check("cmd", {8'h0, cmd_addr, cmd_data}, {8'h0, exp_cmd_q.pop_front()});
      end
      if (frame_err) n_ferr++;
      if (parse_err) n_perr++;
      if (overrun)   n_ovr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(Cpb);
    end
    uart_rx = stop_bit;
    tick(Cpb);
    uart_rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_rx_q.push_back(b);
    send_bits(b, 1'b1);
  endtask

  task automatic send_line(input string body);
    for (int i = 0; i < body.len(); i++) send_byte(body[i]);
    send_byte(8'h0A);
    send_byte(8'h0D);
  endtask

  task automatic snap();
    s_rxv = n_rxv; s_ferr = n_ferr; s_perr = n_perr; s_ovr = n_ovr; s_cmd = n_cmd;
  endtask

  task automatic check_deltas(input string name, input int rxv, input int fe, input int pe,
                              input int ov, input int cmds);
    check({name, "_rxv"},  n_rxv - s_rxv,   rxv);
    check({name, "_ferr"}, n_ferr - s_ferr, fe);
    check({name, "_perr"}, n_perr - s_perr, pe);
    check({name, "_ovr"},  n_ovr - s_ovr,   ov);
    check({name, "_cmds"}, n_cmd - s_cmd,   cmds);
  endtask

  task automatic drain(input string name, input bit with_cmd);
    int k;
    k = 0;
    while ((exp_rx_q.size() != 0 || (with_cmd && exp_cmd_q.size() != 0)) && k < 400) begin
      tick(1);
      k++;
    end
    check({name, "_drain"}, exp_rx_q.size() + (with_cmd ? exp_cmd_q.size() : 0), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_cmd", {8'h0, cmd_addr, cmd_data}, 32'h0);
    check("rst_flags", {27'h0, cmd_valid, rx_byte_valid, frame_err, parse_err, overrun}, 32'h0);
    check("rst_rx_byte", {24'h0, rx_byte}, 32'h0);
    reset = 1'b0;
    tick(5);

    // Basic line, consumer always ready
    snap();
    exp_cmd_q.push_back({16'h1234, 8'hAB});
    send_line("0x1234 0xAB");
    tick(4);
    drain("basic", 1'b1);
    check_deltas("basic", 13, 0, 0, 0, 1);

    // Lower-case hex digits
    snap();
    exp_cmd_q.push_back({16'hBEEF, 8'h0C});
    send_line("0xbeef 0x0c");
    tick(4);
    drain("lower", 1'b1);
    check_deltas("lower", 13, 0, 0, 0, 1);

    // Bad character then resync on the following line
    snap();
    send_line("0x12G4 0x00");
    exp_cmd_q.push_back({16'h0001, 8'h02});
    send_line("0x0001 0x02");
    tick(4);
    drain("resync", 1'b1);
    check_deltas("resync", 26, 0, 1, 0, 1);

    // Stop bit low
    snap();
    send_bits(8'h55, 1'b0);
    tick(3 * Cpb);
    check_deltas("frame", 0, 1, 0, 0, 0);

    // Short low glitch shorter than half a bit
    snap();
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(3 * Cpb);
    check_deltas("glitch", 0, 0, 0, 0, 0);

    // Backpressure: second command is dropped
    cmd_ready = 1'b0;
    snap();
    exp_cmd_q.push_back({16'h1111, 8'h22});
    send_line("0x1111 0x22");
    send_line("0x3333 0x44");
    tick(4);
    drain("bp", 1'b0);
    check("bp_valid_held", {31'h0, cmd_valid}, 32'h1);
    check("bp_held_vals", {8'h0, cmd_addr, cmd_data}, {8'h0, 16'h1111, 8'h22});
    check_deltas("bp", 26, 0, 0, 1, 0);
    cmd_ready = 1'b1;
    tick(1);
    check("bp_valid_drop", {31'h0, cmd_valid}, 32'h0);
    check("bp_accepted", n_cmd - s_cmd, 1);

    // Reset in the middle of a byte, then a clean line
    send_byte(8'h30);
    send_byte(8'h78);
    uart_rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 3; i++) begin
      uart_rx = (i < 2) ? 1'b1 : 1'b0;
      tick(Cpb);
    end
    reset = 1'b1;
    uart_rx = 1'b1;
    tick(1);
    check("mid_rst_cmd", {8'h0, cmd_addr, cmd_data}, 32'h0);
    check("mid_rst_flags", {27'h0, cmd_valid, rx_byte_valid, frame_err, parse_err, overrun},
          32'h0);
    check("mid_rst_rx_byte", {24'h0, rx_byte}, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2 * Cpb);
    snap();
    exp_cmd_q.push_back({16'h3456, 8'h78});
    send_line("0x3456 0x78");
    tick(4);
    drain("post_rst", 1'b1);
    check_deltas("post_rst", 13, 0, 0, 0, 1);

    check("final_rx_q", exp_rx_q.size(), 0);
    check("final_cmd_q", exp_cmd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_hex_cmd_rx.md
Name: uart_hex_cmd_rx

Overview:
- Host-to-board counterpart of the bus monitor's UART hex reporter.
- Receives 8N1 serial bytes on uart_rx and parses text lines of the same format the reporter emits: "0xAAAA 0xDD" followed by LF (0x0A) then CR (0x0D).
- Delivers the decoded 16-bit address and 8-bit value on a valid/ready interface for the RC2014 bus-side logic, such as a write injector or ROM patcher.
- Sits beside uart_tx in the fpga_clk domain.

Parameters:
- CLKS_PER_BIT, 868, fpga clock cycles per UART bit (100 MHz / 115200); minimum 4.

Ports:
- clk  input  1  fpga clock.
- reset  input  1  asynchronous, active-high reset.
- uart_rx  input  1  serial line, idle high, asynchronous to clk.
- cmd_addr  output  16  parsed address.
- cmd_data  output  8  parsed value.
- cmd_valid  output  1  command available; held until accepted.
- cmd_ready  input  1  consumer accepts when cmd_valid && cmd_ready at a clk edge.
- rx_byte  output  8  last received byte.
- rx_byte_valid  output  1  one-cycle pulse per correctly framed byte.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parse_err  output  1  one-cycle pulse on an unexpected character.
- overrun  output  1  one-cycle pulse when a completed command is dropped.

Behaviour:
- Reset:
  - All outputs 0.
  - Receiver in R_IDLE, parser in P_0, bit counter and baud counter 0.
  - Line sync flops preset to 1.
  - Reset asserted mid-byte or mid-line discards partial state.
- Input sync: uart_rx passes through 2 flops; all receiver logic uses the synced value (2-cycle latency).
- Receiver FSM:
  - R_IDLE: synced line low -> R_START, baud counter cleared.
  - R_START: at count CLKS_PER_BIT/2 (integer divide) sample the line. Low -> R_DATA, bit index 0. High -> glitch, return to R_IDLE with no error.
  - R_DATA: sample every CLKS_PER_BIT cycles; bits shift in LSB first; after the 8th sample -> R_STOP.
  - R_STOP: sample after CLKS_PER_BIT.
    - High: rx_byte updated and rx_byte_valid pulses on the same edge; -> R_IDLE.
    - Low: frame_err pulses, byte discarded; -> R_WAIT.
  - R_WAIT: stay until the line is high for 1 cycle, then -> R_IDLE.
- Parser FSM (advances only on rx_byte_valid):
  - Sequence: P_0 '0', P_X 'x'/'X', P_A (4 hex chars, MSB nibble first), P_SP ' ', P_0B '0', P_XB 'x'/'X', P_D (2 hex chars, high nibble first), P_LF 0x0A, P_CR 0x0D.
  - Hex chars accepted: '0'-'9', 'A'-'F', 'a'-'f'. A nibble counter tracks position in P_A/P_D.
  - Any other byte in any state: parse_err pulses, partial address/data discarded, -> P_SYNC.
  - P_SYNC: discard bytes until 0x0D, then -> P_0; no further parse_err while in P_SYNC.
  - 0x0D received in P_0 is ignored (blank line), no error.
  - On 0x0D in P_CR the command completes; parser -> P_0.
- Output handshake:
  - Completion with cmd_valid low: cmd_addr/cmd_data load and cmd_valid rises on the edge after the CR's rx_byte_valid pulse (1-cycle latency).
  - cmd_addr/cmd_data are stable while cmd_valid is high.
  - cmd_valid && cmd_ready clears cmd_valid the next edge.
  - Completion while cmd_valid is high and cmd_ready is low: new command dropped, overrun pulses, held values unchanged.
  - Completion on the same cycle as acceptance: new values load and cmd_valid stays high, no overrun.
- Frame errors do not reset the parser; the lost byte surfaces as a parse_err on the next mismatch.

Test Plan:
- Send "0x1234 0xAB\n\r" at CLKS_PER_BIT=8 with cmd_ready=1 -> cmd_valid pulses once with cmd_addr=0x1234, cmd_data=0xAB; 13 rx_byte_valid pulses; no error pulses.
- Lower-case hex: "0xbeef 0x0c\n\r" -> cmd_addr=0xBEEF, cmd_data=0x0C.
- Corruption and resync: send "0x12G4 0x00\n\r" then "0x0001 0x02\n\r" -> parse_err pulses once at 'G', no command from the first line; second line yields 0x0001/0x02.
- Framing errors:
  - Stop bit driven low on a byte -> frame_err pulses once, rx_byte_valid absent.
  - 4-cycle low glitch at CLKS_PER_BIT=8 -> no byte, no errors.
- Backpressure: cmd_ready=0, two valid lines -> first command held (cmd_valid high, values of line 1), overrun pulses at second CR; then cmd_ready=1 -> cmd_valid drops after one cycle.
- Reset mid-byte: assert reset during R_DATA of '3' -> all outputs 0; after release, a full line parses correctly.
